nibble_word_assembler: RTL and testbench

Reassembles narrow nibble beats into full-width data words: the inverse of the slice-and-concatenate fan-out that splits a 32-bit bus into narrow fields for leaf instances. It sits between a narrow serial field source and a 32-bit consumer. Each word is built LSB-first with a counter and an accumulator, closed by a terminator or by reaching full width, and held in an output register under a valid/ready handshake.

---
 rtl/nibble_word_assembler.sv | 130 +++++++++++++
 tb/tb_nibble_word_assembler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_word_assembler
//  Purpose  : Rebuilds DATA_W-bit words from NIB_W-bit beats. Beats are
//             packed LSB-first into an accumulator. A word closes when a beat
//             carries in_last or when the word reaches full width. The word
//             is then held in an output register under a valid/ready
//             handshake.
//  Macro    : NIBBLE_PARITY_EN - when defined, each beat is checked for even
//             parity over {in_par, in_nib}, and out_err reports the OR of the
//             beat errors across the word. When undefined, in_par is ignored
//             and out_err is tied to 0.
//  Ports    : clk, rst                    clock, async active-high reset
//             in_valid/in_ready           beat handshake
//             in_nib, in_last, in_par     beat data, terminator, parity bit
//             out_valid/out_ready         word handshake
//             out_data, out_count         assembled word, beats in word (1..N)
//             out_err                     parity error seen in this word
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_word_assembler #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NIB_W-1:0]                       in_nib,
  input  logic                                   in_last,
  input  logic                                   in_par,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_W-1:0]                      out_data,
  output logic [$clog2(DATA_W/NIB_W+1)-1:0]      out_count,
  output logic                                   out_err
);

  localparam int N     = DATA_W / NIB_W;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_valid;

  logic [DATA_W-1:0] w_merged;
  logic              w_accept;
  logic              w_complete;
  logic              w_beat_err;

  // Ready only depends on the output register state and the consumer.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = in_last || (r_cnt == c_cnt_last);

  // Accumulator with the current beat dropped into slot r_cnt. Slots above
  // r_cnt are still zero because the accumulator is cleared on every close.
  always_comb begin
    w_merged = r_acc;
    w_merged[r_cnt*NIB_W +: NIB_W] = in_nib;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // A completed transfer drops valid; a completing beat accepted in the
      // same cycle overrides this below and reloads the register.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_complete) begin
          r_out_data  <= w_merged;
          r_out_count <= r_cnt + c_cnt_one;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_merged;
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end
  end

`ifdef NIBBLE_PARITY_EN
  logic r_acc_err;
  logic r_out_err;

  // Even parity: a nonzero XOR across data and parity bit flags an error.
  assign w_beat_err = ^{in_par, in_nib};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_err <= 1'b0;
      r_out_err <= 1'b0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_out_err <= r_acc_err | w_beat_err;
        r_acc_err <= 1'b0;
      end else begin
        r_acc_err <= r_acc_err | w_beat_err;
      end
    end
  end

  assign out_err = r_out_err;
`else
  logic w_unused_par;
  assign w_unused_par = in_par;
  assign w_beat_err   = 1'b0;
  assign out_err      = w_beat_err;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_nibble_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_word_assembler
//  Purpose  : Self-checking bench for nibble_word_assembler. A table of words
//             (beats + hand-computed result) is replayed in a loop, followed
//             by directed sequences for the multi-cycle corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_word_assembler;

  localparam int DATA_W = 32;
  localparam int NIB_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NIB_W-1:0]  in_nib;
  logic              in_last;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_err;

  int tests_run;
  int tests_failed;

  nibble_word_assembler #(
    .DATA_W (DATA_W),
    .NIB_W  (NIB_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nib    (in_nib),
    .in_last   (in_last),
    .in_par    (in_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nbeats;
    logic [31:0] beats;     // beat k in bits [4k+3:4k]
    logic        use_last;  // assert in_last on the final beat
    logic [31:0] exp_data;
    logic [3:0]  exp_count;
  } word_vec_t;

  word_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one beat from a negedge and holds it until accepted on a rising
  // edge; returns #1 after that edge with in_valid dropped.
  task automatic send_beat(input logic [3:0] n, input logic l, input logic p);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_nib   = n;
    in_last  = l;
    in_par   = p;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL beat_accept_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_nib    = '0;
    in_last   = 1'b0;
    in_par    = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{"full8",   8, 32'h87654321, 1'b0, 32'h87654321, 4'd8};
    vecs[1] = '{"short3",  3, 32'h00000CBA, 1'b1, 32'h00000CBA, 4'd3};
    vecs[2] = '{"single",  1, 32'h00000009, 1'b1, 32'h00000009, 4'd1};
    vecs[3] = '{"full8l",  8, 32'h89ABCDEF, 1'b1, 32'h89ABCDEF, 4'd8};
    vecs[4] = '{"two",     2, 32'h00000070, 1'b1, 32'h00000070, 4'd2};

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full word: valid must stay low until beat 8, then last exactly one cycle
    for (int b = 0; b < 8; b++) begin
      send_beat(4'(b + 1), 1'b0, ^(4'(b + 1)));
      if (b == 6) check("full_valid_before_end", {31'd0, out_valid}, 32'd0);
    end
    check("full_valid",  {31'd0, out_valid}, 32'd1);
    check("full_data",   out_data,           32'h87654321);
    check("full_count",  {28'd0, out_count}, 32'd8);
    @(posedge clk);
    #1;
    check("full_valid_one_cycle", {31'd0, out_valid}, 32'd0);

    // Table of words
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        logic [3:0] nb;
        nb = vecs[v].beats[b*4 +: 4];
        send_beat(nb, vecs[v].use_last && (b == vecs[v].nbeats - 1), ^nb);
      end
      check({vecs[v].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({vecs[v].name, "_data"},  out_data,           vecs[v].exp_data);
      check({vecs[v].name, "_count"}, {28'd0, out_count}, {28'd0, vecs[v].exp_count});
      check({vecs[v].name, "_err"},   {31'd0, out_err},   32'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure: word held for 5 cycles, pending beat not lost
    out_ready = 1'b0;
    send_beat(4'h1, 1'b0, 1'b1);
    send_beat(4'h2, 1'b1, 1'b1);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_nib   = 4'h3;
    in_last  = 1'b1;
    in_par   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      check("bp_data",     out_data,           32'h00000021);
      check("bp_count",    {28'd0, out_count}, 32'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    check("bp_reload_data",  out_data,           32'h00000003);
    check("bp_reload_count", {28'd0, out_count}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Back-to-back single-beat words
    send_beat(4'h5, 1'b1, 1'b0);
    check("b2b_valid0", {31'd0, out_valid}, 32'd1);
    check("b2b_data0",  out_data,           32'h00000005);
    send_beat(4'h6, 1'b1, 1'b0);
    check("b2b_valid1", {31'd0, out_valid}, 32'd1);
    check("b2b_data1",  out_data,           32'h00000006);
    check("b2b_count1", {28'd0, out_count}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Reset mid-word: partial word discarded
    send_beat(4'h1, 1'b0, 1'b1);
    send_beat(4'h2, 1'b0, 1'b1);
    send_beat(4'h3, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_data",  out_data,           32'd0);
    check("mrst_count", {28'd0, out_count}, 32'd0);
    check("mrst_err",   {31'd0, out_err},   32'd0);
    check("mrst_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    send_beat(4'hF, 1'b1, 1'b0);
    check("mrst_after_valid", {31'd0, out_valid}, 32'd1);
    check("mrst_after_data",  out_data,           32'h0000000F);
    check("mrst_after_count", {28'd0, out_count}, 32'd1);
    @(posedge clk);
    #1;

    // Parity: beat 0x3 with in_par=1 inside a 4-beat word
    send_beat(4'h1, 1'b0, 1'b1);
    send_beat(4'h3, 1'b0, 1'b1);
    send_beat(4'h5, 1'b0, 1'b0);
    send_beat(4'h7, 1'b1, 1'b1);
    check("par_data", out_data, 32'h00007531);
`ifdef NIBBLE_PARITY_EN
    check("par_err_bad", {31'd0, out_err}, 32'd1);
`else
    check("par_err_off", {31'd0, out_err}, 32'd0);
`endif
    send_beat(4'h2, 1'b0, 1'b1);
    send_beat(4'h4, 1'b1, 1'b1);
    check("par_clean_data", out_data,         32'h00000042);
    check("par_err_clean",  {31'd0, out_err}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
